cmd_frame_parser: RTL and testbench

Parametrised UART command-frame parser between the UART receiver/transmitter and the GPU configuration memories. Assembles received bytes into WORD_BYTES-wide big-endian words, validates a framed command (opcode, length, base address, payload, terminator) and streams the payload words to a generic register-file write port. Handshakes with the host via ACK/NAK bytes and adds an inter-byte timeout and error reporting.

---
 rtl/cmd_frame_parser.sv | 254 +++++++++++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_parser.sv
// UART command-frame parser: assembles big-endian words, validates opcode/length/address/terminator
// framing and streams payload words to a register-file write port with ACK/NAK handshaking.
module cmd_frame_parser #(
  parameter int unsigned WORD_BYTES  = 2,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  logic                      iClock,
  input  logic                      iReset_n,
  input  logic [7:0]                iRxByte,
  input  logic                      iRxReady,
  input  logic                      iRxError,
  input  logic                      iTxSent,
  output logic [7:0]                oTxByte,
  output logic                      oTxStart,
  output logic                      oWrEn,
  output logic [ADDR_W-1:0]         oWrAddr,
  output logic [8*WORD_BYTES-1:0]   oWrData,
  output logic [7:0]                oOpcode,
  output logic                      oBusy,
  output logic                      oFrameDone,
  output logic                      oFrameOk
);

  localparam int unsigned W    = 8 * WORD_BYTES;
  localparam int unsigned BcW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [3:0] {
    StIdle, StSendAck, StWaitAck, StLen, StCmd2, StAddr, StData, StEnd, StSendStat, StWaitStat
  } state_e;

  state_e            state_q, state_d;
  logic [BcW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [W-1:0]      word_q, word_d;
  logic [W-1:0]      hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [7:0]        opc_q, opc_d;
  logic [W-1:0]      len_q, len_d;
  logic [W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              stat_ok_q, stat_ok_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_start_q, tx_start_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]      wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;

  logic [W+7:0] shifted;
  logic [W-1:0] asm_word, cur_word;
  logic         rx_ok, word_done, cur_vld, timed, abortable, tmo_hit, opc_ok, err;

  always_comb begin
    shifted   = {word_q, iRxByte};
    asm_word  = shifted[W-1:0];
    rx_ok     = iRxReady && !iRxError;
    word_done = rx_ok && (byte_cnt_q == BcW'(WORD_BYTES - 1));
    // A held word (captured while the ACK was in flight) is processed before any new one.
    cur_vld   = hold_vld_q || word_done;
    cur_word  = hold_vld_q ? hold_q : asm_word;
    timed     = state_q inside {StLen, StCmd2, StAddr, StData, StEnd};
    abortable = timed || (state_q == StSendAck) || (state_q == StWaitAck);
    tmo_hit   = timed && (tmo_q == TmoW'(TIMEOUT_CYC - 1));
    opc_ok    = (asm_word == {WORD_BYTES{asm_word[7:0]}}) &&
                (asm_word[7:0] != 8'h00) && (asm_word[7:0] != 8'hFF);
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    opc_d      = opc_q;
    len_d      = len_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    stat_ok_d  = stat_ok_q;
    tx_byte_d  = tx_byte_q;
    tx_start_d = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    ok_d       = 1'b0;
    err        = 1'b0;

    if (rx_ok) begin
      word_d     = asm_word;
      byte_cnt_d = word_done ? '0 : byte_cnt_q + BcW'(1);
    end
    // Consuming the held word; a word completing in the same cycle takes its place.
    if (timed && hold_vld_q) begin
      hold_vld_d = word_done;
      hold_d     = asm_word;
    end

    case (state_q)
      StIdle: begin
        if (iRxError) begin
          byte_cnt_d = '0;
        end else if (word_done && opc_ok) begin
          opc_d      = asm_word[7:0];
          state_d    = StSendAck;
          tx_start_d = 1'b1;
          tx_byte_d  = ACK_BYTE;
        end
      end
      StSendAck, StWaitAck: begin
        if (word_done) begin
          if (hold_vld_q) begin
            err = 1'b1;
          end else begin
            hold_d     = asm_word;
            hold_vld_d = 1'b1;
          end
        end
        if (state_q == StSendAck) state_d = StWaitAck;
        else if (iTxSent)         state_d = StLen;
      end
      StLen: begin
        if (cur_vld) begin
          if (cur_word == '0 || cur_word > W'(MAX_LEN)) begin
            err = 1'b1;
          end else begin
            len_d   = cur_word;
            state_d = StCmd2;
          end
        end
      end
      StCmd2: begin
        if (cur_vld) begin
          if (cur_word != {WORD_BYTES{opc_q}}) err = 1'b1;
          else                                 state_d = StAddr;
        end
      end
      StAddr: begin
        if (cur_vld) begin
          addr_d  = ADDR_W'(cur_word);
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (cur_vld) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = cur_word;
          addr_d    = addr_q + ADDR_W'(1);
          idx_d     = idx_q + W'(1);
          if (idx_q == len_q - W'(1)) state_d = StEnd;
        end
      end
      StEnd: begin
        if (cur_vld) begin
          if (cur_word != '1) begin
            err = 1'b1;
          end else begin
            state_d    = StSendStat;
            tx_start_d = 1'b1;
            tx_byte_d  = ACK_BYTE;
            stat_ok_d  = 1'b1;
          end
        end
      end
      StSendStat: state_d = StWaitStat;
      StWaitStat: begin
        if (iTxSent) begin
          state_d = StIdle;
          done_d  = 1'b1;
          ok_d    = stat_ok_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abortable && (iRxError || err || tmo_hit)) begin
      state_d    = StSendStat;
      tx_start_d = 1'b1;
      tx_byte_d  = NAK_BYTE;
      stat_ok_d  = 1'b0;
    end

    if (state_d inside {StIdle, StSendStat, StWaitStat}) hold_vld_d = 1'b0;
    if (state_d == StIdle && state_q != StIdle) byte_cnt_d = '0;

    if (iRxReady || (state_d != state_q) || !timed) tmo_d = '0;
    else                                            tmo_d = tmo_q + TmoW'(1);

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      word_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      opc_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      tmo_q      <= '0;
      stat_ok_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_start_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      opc_q      <= opc_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      stat_ok_q  <= stat_ok_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
    end
  end

  assign oTxByte    = tx_byte_q;
  assign oTxStart   = tx_start_q;
  assign oWrEn      = wr_en_q;
  assign oWrAddr    = wr_addr_q;
  assign oWrData    = wr_data_q;
  assign oOpcode    = opc_q;
  assign oBusy      = busy_q;
  assign oFrameDone = done_q;
  assign oFrameOk   = ok_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: a frame table plus hand sequences, with scoreboard queues for
// transmitted bytes, register writes and frame results.
module tb_cmd_frame_parser;

  localparam int unsigned TIMEOUT_CYC = 4096;

  logic        iClock = 1'b0;
  logic        iReset_n = 1'b0;
  logic [7:0]  iRxByte = 8'h00;
  logic        iRxReady = 1'b0;
  logic        iRxError = 1'b0;
  logic        iTxSent = 1'b0;
  logic [7:0]  oTxByte;
  logic        oTxStart;
  logic        oWrEn;
  logic [7:0]  oWrAddr;
  logic [15:0] oWrData;
  logic [7:0]  oOpcode;
  logic        oBusy;
  logic        oFrameDone;
  logic        oFrameOk;

  cmd_frame_parser #(
    .WORD_BYTES (2),
    .MAX_LEN    (16),
    .ADDR_W     (8),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .ACK_BYTE   (8'h06),
    .NAK_BYTE   (8'h15)
  ) dut (
    .iClock    (iClock),
    .iReset_n  (iReset_n),
    .iRxByte   (iRxByte),
    .iRxReady  (iRxReady),
    .iRxError  (iRxError),
    .iTxSent   (iTxSent),
    .oTxByte   (oTxByte),
    .oTxStart  (oTxStart),
    .oWrEn     (oWrEn),
    .oWrAddr   (oWrAddr),
    .oWrData   (oWrData),
    .oOpcode   (oOpcode),
    .oBusy     (oBusy),
    .oFrameDone(oFrameDone),
    .oFrameOk  (oFrameOk)
  );

  always #5 iClock = ~iClock;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    string       name;
    logic [15:0] opc, len, cmd2, addr, dbase, dstep;
    int          ndata;
    logic [15:0] endw;
    int          nsend, nwr;
    bit          ok, early;
  } frame_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  bit         exp_done[$];

  int n_chk = 0, n_fail = 0;
  int tx_start_cnt = 0, tx_sent_cnt = 0, done_cnt = 0;
  int tx_delay = 3;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  // Transmitter model: finishes each requested byte tx_delay cycles later.
  always begin
    @(negedge iClock);
    if (oTxStart) begin
      repeat (tx_delay) @(posedge iClock);
      #1 iTxSent = 1'b1;
      @(posedge iClock);
      #1 iTxSent = 1'b0;
      tx_sent_cnt++;
    end
  end

  always @(negedge iClock) begin
    if (oTxStart) begin
      tx_start_cnt++;
      if (exp_tx.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL tx_unexpected: got byte %0h required none", oTxByte);
      end else begin
        chk("tx_byte", 32'(oTxByte), 32'(exp_tx.pop_front()));
      end
    end
    if (oWrEn) begin
      if (exp_wr.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL wr_unexpected: got %0h@%0h required none", oWrData, oWrAddr);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(oWrAddr), 32'(e.addr));
        chk("wr_data", 32'(oWrData), 32'(e.data));
      end
    end
    if (oFrameDone) begin
      done_cnt++;
      if (exp_done.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done_unexpected: got ok=%0b required none", oFrameOk);
      end else begin
        chk("frame_ok", 32'(oFrameOk), 32'(exp_done.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge iClock);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_err = 1'b0);
    iRxByte = b; iRxReady = 1'b1; iRxError = with_err;
    tick();
    iRxReady = 1'b0; iRxError = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_tx(input int n0, input string name);
    int t = 0;
    while (tx_sent_cnt == n0 && t < 200) begin tick(); t++; end
    chk({name, "_ack_seen"}, 32'(tx_sent_cnt > n0), 32'd1);
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int t = 0;
    while (done_cnt == d0 && t < budget) begin tick(); t++; end
    chk({name, "_done_seen"}, 32'(done_cnt > d0), 32'd1);
  endtask

  task automatic run_frame(input frame_t f);
    logic [15:0] w[$];
    int n0, d0, first;
    exp_tx.push_back(8'h06);
    for (int k = 0; k < f.nwr; k++)
      exp_wr.push_back('{addr: f.addr[7:0] + 8'(k), data: f.dbase + 16'(k) * f.dstep});
    exp_tx.push_back(f.ok ? 8'h06 : 8'h15);
    exp_done.push_back(f.ok);
    w = {f.len, f.cmd2, f.addr};
    for (int k = 0; k < f.ndata; k++) w.push_back(f.dbase + 16'(k) * f.dstep);
    w.push_back(f.endw);
    tx_delay = f.early ? 20 : 3;
    n0 = tx_sent_cnt;
    d0 = done_cnt;
    send_word(f.opc);
    first = 0;
    if (f.early) begin
      send_word(w[0]);
      first = 1;
    end
    wait_tx(n0, f.name);
    if (!f.early) begin
      chk({f.name, "_busy"}, 32'(oBusy), 32'd1);
      chk({f.name, "_opcode"}, 32'(oOpcode), 32'(f.opc[7:0]));
    end
    for (int i = first; i < f.nsend; i++) send_word(w[i]);
    wait_done(d0, 300, f.name);
    tick();
    chk({f.name, "_idle"}, 32'(oBusy), 32'd0);
    tx_delay = 3;
  endtask

  frame_t tbl[8];

  initial begin
    int d0, s0;
    tbl[0] = '{"good",     16'hAAAA, 16'h0003, 16'hAAAA, 16'h0010, 16'h1234, 16'h1111, 3,
               16'hFFFF, 7, 3, 1'b1, 1'b0};
    tbl[1] = '{"wrap",     16'h5555, 16'h0002, 16'h5555, 16'h00FF, 16'h0A0B, 16'h0101, 2,
               16'hFFFF, 6, 2, 1'b1, 1'b0};
    tbl[2] = '{"len_zero", 16'hBBBB, 16'h0000, 16'hBBBB, 16'h0000, 16'h0000, 16'h0000, 0,
               16'hFFFF, 1, 0, 1'b0, 1'b0};
    tbl[3] = '{"len_over", 16'hBBBB, 16'h0011, 16'hBBBB, 16'h0000, 16'h0000, 16'h0000, 0,
               16'hFFFF, 1, 0, 1'b0, 1'b0};
    tbl[4] = '{"cmd2_bad", 16'hCCCC, 16'h0001, 16'hCCCD, 16'h0000, 16'h0000, 16'h0000, 0,
               16'hFFFF, 2, 0, 1'b0, 1'b0};
    tbl[5] = '{"end_bad",  16'hCCCC, 16'h0001, 16'hCCCC, 16'h0020, 16'h0E0F, 16'h0000, 1,
               16'hFFFE, 5, 1, 1'b0, 1'b0};
    tbl[6] = '{"len_max",  16'h1111, 16'h0010, 16'h1111, 16'h0040, 16'h0100, 16'h0101, 16,
               16'hFFFF, 20, 16, 1'b1, 1'b0};
    tbl[7] = '{"held_len", 16'h5A5A, 16'h0002, 16'h5A5A, 16'h0080, 16'h7000, 16'h0001, 2,
               16'hFFFF, 6, 2, 1'b1, 1'b1};

    repeat (3) tick();
    chk("rst_txbyte", 32'(oTxByte), 32'd0);
    chk("rst_txstart", 32'(oTxStart), 32'd0);
    chk("rst_wren", 32'(oWrEn), 32'd0);
    chk("rst_wraddr", 32'(oWrAddr), 32'd0);
    chk("rst_wrdata", 32'(oWrData), 32'd0);
    chk("rst_opcode", 32'(oOpcode), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oFrameDone), 32'd0);
    chk("rst_ok", 32'(oFrameOk), 32'd0);
    iReset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);

    // Holding-register overflow: two words complete while the ACK is still in flight.
    tx_delay = 40;
    exp_tx.push_back(8'h06); exp_tx.push_back(8'h15); exp_done.push_back(1'b0);
    d0 = done_cnt;
    send_word(16'h2222); send_word(16'h0001); send_word(16'h2222);
    wait_done(d0, 300, "overflow");
    tick();
    tx_delay = 3;

    // Inter-byte timeout after one ADDR byte.
    exp_tx.push_back(8'h06); exp_tx.push_back(8'h15); exp_done.push_back(1'b0);
    d0 = done_cnt;
    s0 = tx_sent_cnt;
    send_word(16'h7777);
    wait_tx(s0, "timeout");
    send_word(16'h0001); send_word(16'h7777); send_byte(8'h00);
    s0 = tx_start_cnt;
    repeat (TIMEOUT_CYC - 50) tick();
    chk("timeout_not_early", 32'(tx_start_cnt), 32'(s0));
    wait_done(d0, 200, "timeout");
    tick();

    // Receiver error during DATA after one payload word.
    exp_tx.push_back(8'h06); exp_wr.push_back('{addr: 8'h30, data: 16'h0C0D});
    exp_tx.push_back(8'h15); exp_done.push_back(1'b0);
    d0 = done_cnt;
    s0 = tx_sent_cnt;
    send_word(16'h3C3C);
    wait_tx(s0, "rxerr");
    send_word(16'h0002); send_word(16'h3C3C); send_word(16'h0030); send_word(16'h0C0D);
    iRxError = 1'b1; tick(); iRxError = 1'b0; tick();
    wait_done(d0, 300, "rxerr");
    tick();

    // In IDLE: partial byte, then byte+error together is dropped and clears the count.
    send_byte(8'hAB);
    send_byte(8'hCD, 1'b1);
    run_frame('{"err_drop", 16'h9999, 16'h0001, 16'h9999, 16'h0070, 16'h0BEE, 16'h0000, 1,
                16'hFFFF, 5, 1, 1'b1, 1'b0});

    // Reset mid-DATA: no status byte and no frame-done from the aborted frame.
    exp_tx.push_back(8'h06); exp_wr.push_back('{addr: 8'h60, data: 16'h0101});
    d0 = done_cnt;
    s0 = tx_sent_cnt;
    send_word(16'h4444);
    wait_tx(s0, "rst_mid");
    send_word(16'h0003); send_word(16'h4444); send_word(16'h0060); send_word(16'h0101);
    tick();
    iReset_n = 1'b0;
    repeat (2) tick();
    chk("rst_mid_busy", 32'(oBusy), 32'd0);
    chk("rst_mid_opcode", 32'(oOpcode), 32'd0);
    chk("rst_mid_wraddr", 32'(oWrAddr), 32'd0);
    iReset_n = 1'b1;
    tick();
    s0 = tx_start_cnt;
    send_word(16'h1234);
    repeat (20) tick();
    chk("garbage_no_tx", 32'(tx_start_cnt), 32'(s0));
    chk("garbage_idle", 32'(oBusy), 32'd0);
    chk("rst_mid_no_done", 32'(done_cnt), 32'(d0));
    chk("rst_mid_wr_drained", 32'(exp_wr.size()), 32'd0);
    run_frame(tbl[0]);

    repeat (10) tick();
    chk("end_tx_q", 32'(exp_tx.size()), 32'd0);
    chk("end_wr_q", 32'(exp_wr.size()), 32'd0);
    chk("end_done_q", 32'(exp_done.size()), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
